fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory handshake, owns the PC,
// and feeds the IF/ID register through a one-entry skid buffer when decode stalls.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [6:0]  if_id_opcode
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        v_q, v_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] iinstr_q, iinstr_d;
    logic [31:0] tgt_aligned;

    assign tgt_aligned = {branch_target[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            tgt_q        <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            v_q          <= 1'b0;
            ipc_q        <= '0;
            iinstr_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            v_q          <= v_d;
            ipc_q        <= ipc_d;
            iinstr_q     <= iinstr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH: begin
                if (branch_taken)            state_d = imem_ready ? FETCH : DISCARD;
                else if (imem_ready && stall) state_d = HOLD;
            end
            HOLD:    if (branch_taken || !stall) state_d = FETCH;
            DISCARD: if (imem_ready) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state. IF/ID holds under stall unless flushed; otherwise it
    // bubbles, and a delivered word below overrides the bubble.
    always_comb begin
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        ipc_d        = ipc_q;
        iinstr_d     = iinstr_q;
        v_d          = (branch_taken || !stall) ? 1'b0 : v_q;
        case (state_q)
            IDLE: if (branch_taken) pc_d = tgt_aligned;
            FETCH: begin
                if (branch_taken) begin
                    if (imem_ready) pc_d  = tgt_aligned;
                    else            tgt_d = tgt_aligned;
                end else if (imem_ready) begin
                    pc_d = pc_q + 32'd4;
                    if (stall) begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                    end else begin
                        ipc_d    = pc_q;
                        iinstr_d = imem_rdata;
                        v_d      = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_d = tgt_aligned;
                end else if (!stall) begin
                    ipc_d    = skid_pc_q;
                    iinstr_d = skid_instr_q;
                    v_d      = 1'b1;
                end
            end
            DISCARD: begin
                // A flush arriving while draining replaces the pending target.
                if (branch_taken) tgt_d = tgt_aligned;
                if (imem_ready)   pc_d  = branch_taken ? tgt_aligned : tgt_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        imem_req     = (state_q == FETCH) || (state_q == DISCARD);
        imem_addr    = pc_q;
        if_id_valid  = v_q;
        if_id_pc     = ipc_q;
        if_id_instr  = iinstr_q;
        if_id_opcode = iinstr_q[6:0];
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based behavioural model.
module tb_fetch_stage;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ready, stall, branch_taken;
    logic [31:0] imem_addr, imem_rdata, branch_target;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_instr;
    logic [6:0]  if_id_opcode;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: "started" = out of the post-reset idle cycle; a non-empty skid queue
    // means fetch is parked; "draining" means an in-flight response must be dropped.
    bit          m_started, m_drain, m_v;
    logic [31:0] m_pc, m_tgt, m_ipc, m_iins;
    logic [63:0] m_skid[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_started = 0; m_drain = 0; m_v = 0;
        m_pc = RPC; m_tgt = '0; m_ipc = '0; m_iins = '0;
        m_skid.delete();
    endtask

    task automatic check_model();
        bit er;
        er = m_started && (m_skid.size() == 0);
        chk("req", {31'b0, imem_req}, {31'b0, er});
        if (er) chk("addr", imem_addr, m_pc);
        chk("valid", {31'b0, if_id_valid}, {31'b0, m_v});
        if (m_v) begin
            chk("if_pc", if_id_pc, m_pc == m_pc ? m_ipc : m_ipc);
            chk("if_instr", if_id_instr, m_iins);
            chk("opcode", {25'b0, if_id_opcode}, {25'b0, m_iins[6:0]});
        end
    endtask

    task automatic m_step(input bit s, input bit b, input logic [31:0] t,
                          input bit r, input logic [31:0] d);
        logic [31:0] ta;
        logic [63:0] e;
        bit keep;
        ta = t & 32'hFFFF_FFFC;
        keep = s && !b;
        if (!keep) m_v = 0;
        if (!m_started) begin
            m_started = 1;
            if (b) m_pc = ta;
        end else if (m_skid.size() != 0) begin
            if (b) begin
                m_skid.delete();
                m_pc = ta;
            end else if (!s) begin
                e = m_skid.pop_front();
                m_ipc = e[63:32]; m_iins = e[31:0]; m_v = 1;
            end
        end else if (m_drain) begin
            if (b) m_tgt = ta;
            if (r) begin
                m_pc = m_tgt;
                m_drain = 0;
            end
        end else if (b) begin
            if (r) m_pc = ta;
            else begin
                m_tgt = ta;
                m_drain = 1;
            end
        end else if (r) begin
            if (s) m_skid.push_back({m_pc, d});
            else begin
                m_ipc = m_pc; m_iins = d; m_v = 1;
            end
            m_pc = m_pc + 32'd4;
        end
    endtask

    // Called at a falling edge; checks current outputs, applies one cycle of inputs.
    task automatic cyc(input bit s, input bit b, input logic [31:0] t,
                       input bit r, input logic [31:0] d);
        stall = s; branch_taken = b; branch_target = t; imem_ready = r; imem_rdata = d;
        check_model();
        @(posedge clk);
        m_step(s, b, t, r, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
        chk("rst_if_pc", if_id_pc, 32'd0);
        chk("rst_if_instr", if_id_instr, 32'd0);
        chk("rst_addr", imem_addr, RPC);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        stall = 0; branch_taken = 0; branch_target = '0; imem_ready = 0; imem_rdata = '0;
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
        do_reset();

        // Zero-wait streaming from reset.
        cyc(0, 0, 0, 1, NOP);
        chk("idle_exit_addr", imem_addr, 32'h0);
        chk("idle_exit_req", {31'b0, imem_req}, 32'd1);
        chk("first_valid", {31'b0, if_id_valid}, 32'd0);
        cyc(0, 0, 0, 1, NOP);
        chk("stream_pc0", if_id_pc, 32'h0);
        chk("stream_addr4", imem_addr, 32'h4);
        chk("stream_opcode", {25'b0, if_id_opcode}, 32'h13);
        cyc(0, 0, 0, 1, NOP);
        chk("stream_pc4", if_id_pc, 32'h4);

        // Stall while word at pc=8 returns.
        cyc(1, 0, 0, 1, 32'h0000_8033);
        chk("hold_req", {31'b0, imem_req}, 32'd0);
        chk("hold_if_pc", if_id_pc, 32'h4);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("hold_if_pc2", if_id_pc, 32'h4);
        cyc(0, 0, 0, 0, 0);
        chk("release_if_pc", if_id_pc, 32'h8);
        chk("release_instr", if_id_instr, 32'h0000_8033);
        chk("release_addr", imem_addr, 32'hC);

        // Flush while memory is slow: drain the old response, then redirect.
        cyc(0, 0, 0, 1, NOP);
        chk("addr16", imem_addr, 32'h10);
        cyc(0, 1, 32'h0000_0103, 0, 0);
        chk("drain_addr", imem_addr, 32'h10);
        chk("drain_req", {31'b0, imem_req}, 32'd1);
        chk("drain_valid", {31'b0, if_id_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("redirect_addr", imem_addr, 32'h100);
        chk("redirect_valid", {31'b0, if_id_valid}, 32'd0);

        // Flush and stall together while parked in the skid buffer.
        cyc(1, 0, 0, 1, NOP);
        chk("park_req", {31'b0, imem_req}, 32'd0);
        cyc(1, 1, 32'h0000_0200, 0, 0);
        chk("skid_flush_valid", {31'b0, if_id_valid}, 32'd0);
        chk("skid_flush_addr", imem_addr, 32'h200);

        // PC wrap.
        cyc(0, 1, 32'hFFFF_FFFC, 1, NOP);
        chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 1, 32'h0000_0067);
        chk("wrap_if_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset while draining.
        cyc(0, 1, 32'h0000_0040, 0, 0);
        chk("pre_rst_drain", {31'b0, imem_req}, 32'd1);
        do_reset();
        cyc(0, 0, 0, 0, 0);
        chk("post_rst_addr", imem_addr, RPC);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else cyc($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom,
                     $urandom_range(0, 3) != 0, $urandom);
        end
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
